mjpg_bitstream_packer: RTL and testbench
========================================

// Module: mjpg_bitstream_packer
// PURPOSE
//  Multi-source JPEG entropy bitstream packer. Arbitrates NSRC variable-length code-word streams,
//  including header/footer and per-component encoders. Packs them MSB-first into bytes and inserts
//  a 0x00 stuff byte after every 0xFF in entropy data. Supports byte alignment (1-fill) and
//  raw, unstuffed header words. Sits between the component encoders and the byte sink.
//  Replaces collision-checked OR-merging with a ready/valid arbiter and downstream backpressure.
// PARAMETERS
//  NSRC        4   number of input sources; index 0 has the highest priority
//  OFIFO_DEPTH 16  output byte FIFO entries (power of 2, >=4)
// PORTS
//  clk        in   1          clock
//  rst        in   1          synchronous, active-high reset
//  s_valid    in   NSRC       source i presents a word
//  s_ready    out  NSRC       source i word accepted this cycle (valid&ready)
//  s_len      in   NSRC*6     bit count 0..32 of source i, slice [6*i+:6]
//  s_data     in   NSRC*32    code bits right-aligned in [s_len-1:0]; bits above s_len are don't-care
//  s_raw      in   NSRC       word is header/marker: no stuffing; s_len must be 0,8,16,24,32
//  s_align    in   NSRC       after appending, pad with 1s to the next byte boundary
//  m_valid    out  1          output byte available
//  m_ready    in   1          sink takes byte when m_valid&m_ready
//  m_data     out  8          output byte
//  bit_rest   out  3          pending bits in the partial byte (acc_cnt mod 8)
//  idle       out  1          accumulator empty and output FIFO empty
//  err        out  1          sticky: s_len>32, or raw word with s_len%8!=0
// BEHAVIOUR
//  Reset: all state cleared; s_ready=0, m_valid=0, m_data=0, bit_rest=0, idle=1, err=0.
//   A reset mid-word or mid-stuff discards all pending bits and bytes.
//  Accumulator: 64-bit acc, count acc_cnt 0..64, MSB-first; raw_mode flag marks its contents raw.
//  Grant: the lowest index i with s_valid[i] whose word fits is accepted.
//   Fit = acc_cnt+len(+pad)<=64, AND
//   raw word: acc_cnt==0 (drained); non-raw word: !raw_mode || acc_cnt==0.
//   At most one s_ready bit is high per cycle. s_ready is combinational from s_valid and state.
//  Append: len bits are shifted in below the existing bits, and acc_cnt+=len.
//   If s_align is set, acc_cnt rounds up to a multiple of 8 and pad bits are 1.
//   raw_mode<=s_raw on the accepting cycle.
//   len=0 is accepted and has no effect unless align is set.
//   len>32 sets err and is treated as 32. A raw word with len%8!=0 sets err, is truncated to floor(len/8)*8.
//  Drain: when acc_cnt>=8 and the FIFO has >=2 free entries, the top byte goes to the FIFO and acc_cnt-=8.
//   Drain and append may occur in the same cycle; the count update is acc_cnt+len(+pad)-8.
//   Fit uses acc_cnt before the drain.
//  Stuffing: a non-raw byte equal to 0xFF is pushed, then 0x00 is pushed the next cycle.
//   Drain stalls during the stuff cycle. A raw 0xFF is never stuffed.
//  raw_mode clears when acc_cnt reaches 0.
//  Output FIFO: m_valid=!empty; m_data=head, held stable while m_valid&!m_ready.
//   Latency: a byte completed on accept cycle N is presented at m_data at N+2 if the FIFO is empty.
//   When the FIFO is full, drain stops and acc fills; then s_ready drops. No data is ever lost.
//  bit_rest=acc_cnt[2:0] registered; idle=(acc_cnt==0)&&empty&&!stuff_pending.
// TESTING
//  Word 0xFFD8 raw len16 on src0 -> m_data FF,D8; no 00; err=0.
//  Src1 len8 0xFF, then len4 0xA, align -> FF,00,AF; bit_rest 0 after.
//  Src1 len3 0b101 + src2 len5 0b10110 same cycle -> src1 first; byte 0xB6 (101|10110).
//  m_ready=0 for 40 cycles while src1 streams 32-bit 0x12345678 -> FIFO fills, then s_ready=0.
//   After release: 12,34,56,78 repeated, no loss.
//  Raw word offered while acc_cnt=3 -> s_ready=0 until an align on another source, then accepted.
//  rst asserted mid-stream (acc_cnt=13, FIFO 5 bytes) -> next cycle m_valid=0, idle=1, bit_rest=0.
//  s_len=40 on src0 -> err=1 sticky, 32 bits consumed.

Source files
------------

// File: rtl/mjpg_bitstream_packer_if.sv
// rtl/mjpg_bitstream_packer_if.sv - source/sink handshake bundle for the JPEG bitstream packer
// Ports: s_valid/s_ready/s_len/s_data/s_raw/s_align per source; m_valid/m_ready/m_data byte sink.
// The slave modport is the packer's view, the master modport is the sources'/sink's view.
interface mjpg_bitstream_packer_if #(
    parameter int NSRC = 4
);
    logic [NSRC-1:0]    s_valid;
    logic [NSRC-1:0]    s_ready;
    logic [NSRC*6-1:0]  s_len;
    logic [NSRC*32-1:0] s_data;
    logic [NSRC-1:0]    s_raw;
    logic [NSRC-1:0]    s_align;
    logic               m_valid;
    logic               m_ready;
    logic [7:0]         m_data;

    modport slave (
        input  s_valid, s_len, s_data, s_raw, s_align, m_ready,
        output s_ready, m_valid, m_data
    );

    modport master (
        output s_valid, s_len, s_data, s_raw, s_align, m_ready,
        input  s_ready, m_valid, m_data
    );
endinterface

// File: rtl/mjpg_bitstream_packer.sv
// rtl/mjpg_bitstream_packer.sv - multi-source JPEG entropy bitstream packer with 0xFF stuffing
// Ports: clk, rst (sync, active-high); bus (slave modport: code-word sources in, byte stream out);
//        bit_rest = pending bits in the partial byte, idle = nothing buffered, err = sticky length error.
module mjpg_bitstream_packer #(
    parameter int NSRC        = 4,
    parameter int OFIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    mjpg_bitstream_packer_if.slave        bus,
    output logic [2:0]                    bit_rest,
    output logic                          idle,
    output logic                          err
);
    localparam int AW = $clog2(OFIFO_DEPTH);

    typedef enum logic {ST_PACK, ST_STUFF} state_t;

    state_t        state_q, state_d;
    logic [63:0]   acc_q, acc_d;
    logic [6:0]    cnt_q, cnt_d;
    logic          raw_mode_q, raw_mode_d;
    logic          err_q;

    logic [7:0]    fifo_mem [OFIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fifo_cnt;
    logic          fifo_empty;
    logic          push, pop;
    logic [7:0]    push_data;

    // Per-source effective length and end position (after optional 1-fill)
    logic [5:0]    eff_len [NSRC];
    logic [6:0]    end_cnt [NSRC];
    logic          bad_len [NSRC];
    logic [NSRC-1:0] fits, grant;

    logic          accept, drain;
    logic [5:0]    sel_len;
    logic [6:0]    sel_end;
    logic [31:0]   sel_data;
    logic          sel_raw, sel_bad;
    logic [6:0]    sum_cnt;
    logic [63:0]   word_bits, pad_mask, acc_sum;
    logic [6:0]    cnt_sum;

    always_comb begin
        grant    = '0;
        fits     = '0;
        sel_len  = '0;
        sel_end  = cnt_q;
        sel_data = '0;
        sel_raw  = 1'b0;
        sel_bad  = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            logic [5:0] l;
            logic [6:0] s;
            l          = bus.s_len[6*i +: 6];
            bad_len[i] = (l > 6'd32) || (bus.s_raw[i] && (l[2:0] != 3'd0));
            if (l > 6'd32)
                l = 6'd32;
            if (bus.s_raw[i])
                l = {l[5:3], 3'b000};
            eff_len[i] = l;
            s          = cnt_q + {1'b0, l};
            end_cnt[i] = bus.s_align[i] ? ((s + 7'd7) & 7'h78) : s;
            // Raw words only start into an empty accumulator; entropy words may not mix into raw bits.
            fits[i]    = (end_cnt[i] <= 7'd64) &&
                         (bus.s_raw[i] ? (cnt_q == 7'd0) : (!raw_mode_q || cnt_q == 7'd0));
        end
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (bus.s_valid[i] && fits[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                sel_len  = eff_len[i];
                sel_end  = end_cnt[i];
                sel_data = bus.s_data[32*i +: 32];
                sel_raw  = bus.s_raw[i];
                sel_bad  = bad_len[i];
            end
        end
    end

    assign bus.s_ready = rst ? '0 : grant;
    assign accept      = |bus.s_ready;

    // New bits land directly below the existing acc_cnt bits; pad 1s fill up to the aligned end.
    always_comb begin
        sum_cnt   = cnt_q + {1'b0, sel_len};
        word_bits = ({32'b0, sel_data & (32'hFFFF_FFFF >> (6'd32 - sel_len))}
                     << (7'd64 - {1'b0, sel_len})) >> cnt_q;
        pad_mask  = (64'hFFFF_FFFF_FFFF_FFFF >> sum_cnt) & ~(64'hFFFF_FFFF_FFFF_FFFF >> sel_end);
        acc_sum   = accept ? (acc_q | word_bits | pad_mask) : acc_q;
        cnt_sum   = accept ? sel_end : cnt_q;
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_sum;
        cnt_d      = cnt_sum;
        push       = 1'b0;
        push_data  = 8'h00;
        drain      = 1'b0;
        // Two free entries keep room for the stuff byte that may follow this one.
        if (state_q == ST_STUFF) begin
            push    = 1'b1;
            state_d = ST_PACK;
        end else if (cnt_q >= 7'd8 && fifo_cnt <= (AW+1)'(OFIFO_DEPTH - 2)) begin
            drain     = 1'b1;
            push      = 1'b1;
            push_data = acc_q[63:56];
            acc_d     = acc_sum << 8;
            cnt_d     = cnt_sum - 7'd8;
            if (!raw_mode_q && acc_q[63:56] == 8'hFF)
                state_d = ST_STUFF;
        end
        raw_mode_d = accept ? sel_raw : raw_mode_q;
        if (cnt_d == 7'd0)
            raw_mode_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_PACK;
            acc_q      <= '0;
            cnt_q      <= '0;
            raw_mode_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            raw_mode_q <= raw_mode_d;
            err_q      <= err_q | (accept & sel_bad);
        end
    end

    assign fifo_empty = (fifo_cnt == '0);
    assign pop        = !fifo_empty && bus.m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= push_data;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            fifo_cnt <= fifo_cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    assign bus.m_valid = !fifo_empty;
    assign bus.m_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];
    assign bit_rest    = cnt_q[2:0];
    assign idle        = (cnt_q == 7'd0) && fifo_empty && (state_q == ST_PACK);
    assign err         = err_q;
endmodule

// File: tb/tb_mjpg_bitstream_packer.sv
// tb/tb_mjpg_bitstream_packer.sv - self-checking bench for mjpg_bitstream_packer
module tb_mjpg_bitstream_packer;
    localparam int NSRC = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] bit_rest;
    logic       idle;
    logic       err;

    mjpg_bitstream_packer_if #(.NSRC(NSRC)) bus ();

    mjpg_bitstream_packer #(.NSRC(NSRC), .OFIFO_DEPTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .bit_rest (bit_rest),
        .idle     (idle),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          src;
        logic [5:0]  len;
        logic [31:0] data;
        logic        raw;
        logic        align;
        int          nexp;
        logic [47:0] exp;
        logic [2:0]  br;
        logic        err;
    } vec_t;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] got [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_bytes(input string name, input int n, input logic [47:0] exp);
        check({name, "_count"}, 64'(got.size()), 64'(n));
        for (int k = 0; k < n && k < got.size(); k++)
            check($sformatf("%s_byte%0d", name, k), 64'(got[k]), 64'(exp[47-8*k -: 8]));
        got.delete();
    endtask

    task automatic apply(input int src, input logic [5:0] len, input logic [31:0] data,
                         input logic raw, input logic align);
        int waited;
        @(negedge clk);
        bus.s_valid[src]        = 1'b1;
        bus.s_len[6*src +: 6]   = len;
        bus.s_data[32*src +: 32] = data;
        bus.s_raw[src]          = raw;
        bus.s_align[src]        = align;
        waited = 0;
        #1;
        while (!bus.s_ready[src] && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check("accept_in_time", 64'(waited < 200), 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.s_valid[src] = 1'b0;
        bus.s_raw[src]   = 1'b0;
        bus.s_align[src] = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst && bus.m_valid && bus.m_ready)
                got.push_back(bus.m_data);
        end
    end

    vec_t vecs [13];

    initial begin
        int          cnt;
        int          w;
        logic [7:0]  pat [4];

        vecs[0]  = '{0, 6'd16, 32'h0000_FFD8, 1'b1, 1'b0, 2, 48'hFFD8_0000_0000, 3'd0, 1'b0};
        vecs[1]  = '{1, 6'd8,  32'h0000_00FF, 1'b0, 1'b0, 2, 48'hFF00_0000_0000, 3'd0, 1'b0};
        vecs[2]  = '{1, 6'd4,  32'h0000_000A, 1'b0, 1'b1, 1, 48'hAF00_0000_0000, 3'd0, 1'b0};
        vecs[3]  = '{2, 6'd12, 32'h0000_0ABC, 1'b0, 1'b0, 1, 48'hAB00_0000_0000, 3'd4, 1'b0};
        vecs[4]  = '{3, 6'd4,  32'h0000_000D, 1'b0, 1'b0, 1, 48'hCD00_0000_0000, 3'd0, 1'b0};
        vecs[5]  = '{1, 6'd32, 32'hFFFF_0012, 1'b0, 1'b0, 6, 48'hFF00_FF00_0012, 3'd0, 1'b0};
        vecs[6]  = '{0, 6'd0,  32'h0000_0000, 1'b0, 1'b1, 0, 48'h0,              3'd0, 1'b0};
        vecs[7]  = '{1, 6'd5,  32'hFFFF_FFFF, 1'b0, 1'b0, 0, 48'h0,              3'd5, 1'b0};
        vecs[8]  = '{2, 6'd0,  32'h0000_0000, 1'b0, 1'b1, 2, 48'hFF00_0000_0000, 3'd0, 1'b0};
        vecs[9]  = '{2, 6'd1,  32'hFFFF_FFFF, 1'b0, 1'b0, 0, 48'h0,              3'd1, 1'b0};
        vecs[10] = '{2, 6'd7,  32'h0000_007F, 1'b0, 1'b0, 2, 48'hFF00_0000_0000, 3'd0, 1'b0};
        vecs[11] = '{3, 6'd12, 32'h0000_0ABC, 1'b1, 1'b0, 1, 48'hBC00_0000_0000, 3'd0, 1'b1};
        vecs[12] = '{0, 6'd40, 32'h89AB_CDEF, 1'b0, 1'b0, 4, 48'h89AB_CDEF_0000, 3'd0, 1'b1};
        pat[0] = 8'h12; pat[1] = 8'h34; pat[2] = 8'h56; pat[3] = 8'h78;

        rst         = 1'b1;
        bus.s_valid = '0;
        bus.s_len   = '0;
        bus.s_data  = '0;
        bus.s_raw   = '0;
        bus.s_align = '0;
        bus.m_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_s_ready",  64'(bus.s_ready), 64'd0);
        check("rst_m_valid",  64'(bus.m_valid), 64'd0);
        check("rst_m_data",   64'(bus.m_data),  64'd0);
        check("rst_bit_rest", 64'(bit_rest),    64'd0);
        check("rst_idle",     64'(idle),        64'd1);
        check("rst_err",      64'(err),         64'd0);

        for (int v = 0; v < 13; v++) begin
            apply(vecs[v].src, vecs[v].len, vecs[v].data, vecs[v].raw, vecs[v].align);
            repeat (16) @(negedge clk);
            check_bytes($sformatf("vec%0d", v), vecs[v].nexp, vecs[v].exp);
            check($sformatf("vec%0d_bit_rest", v), 64'(bit_rest), 64'(vecs[v].br));
            check($sformatf("vec%0d_err", v),      64'(err),      64'(vecs[v].err));
        end

        // Two sources in the same cycle: lower index wins, the other follows.
        @(negedge clk);
        bus.s_valid[1] = 1'b1; bus.s_len[6 +: 6]  = 6'd3; bus.s_data[32 +: 32] = 32'h5;
        bus.s_valid[2] = 1'b1; bus.s_len[12 +: 6] = 6'd5; bus.s_data[64 +: 32] = 32'h16;
        #1;
        check("prio_first", 64'(bus.s_ready), 64'b0010);
        @(posedge clk);
        @(negedge clk);
        bus.s_valid[1] = 1'b0;
        #1;
        check("prio_second", 64'(bus.s_ready), 64'b0100);
        @(posedge clk);
        @(negedge clk);
        bus.s_valid[2] = 1'b0;
        repeat (10) @(negedge clk);
        check_bytes("prio", 1, 48'hB600_0000_0000);
        check("prio_bit_rest", 64'(bit_rest), 64'd0);

        // Raw word waits for a drained accumulator; an align on another source unblocks it.
        apply(1, 6'd3, 32'h5, 1'b0, 1'b0);
        bus.s_valid[0] = 1'b1; bus.s_len[0 +: 6] = 6'd16; bus.s_data[0 +: 32] = 32'hFFD8;
        bus.s_raw[0]   = 1'b1;
        cnt = 0;
        repeat (6) begin
            #1;
            if (bus.s_ready[0]) cnt++;
            @(negedge clk);
        end
        check("raw_blocked", 64'(cnt), 64'd0);
        bus.s_valid[2] = 1'b1; bus.s_len[12 +: 6] = 6'd0; bus.s_align[2] = 1'b1;
        #1;
        check("align_grant", 64'(bus.s_ready), 64'b0100);
        @(posedge clk);
        @(negedge clk);
        bus.s_valid[2] = 1'b0; bus.s_align[2] = 1'b0;
        w = 0;
        #1;
        while (!bus.s_ready[0] && w < 50) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("raw_accept", 64'(w < 50), 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.s_valid[0] = 1'b0; bus.s_raw[0] = 1'b0;
        repeat (10) @(negedge clk);
        check_bytes("raw_wait", 3, 48'hBFFF_D800_0000);

        // Backpressure: 15 FIFO bytes + 40 acc bits = 5 words, then s_ready drops.
        bus.m_ready = 1'b0;
        bus.s_valid[1] = 1'b1; bus.s_len[6 +: 6] = 6'd32; bus.s_data[32 +: 32] = 32'h1234_5678;
        cnt = 0;
        repeat (40) begin
            #1;
            if (bus.s_ready[1]) cnt++;
            @(negedge clk);
        end
        #1;
        check("bp_words_taken", 64'(cnt), 64'd5);
        check("bp_s_ready_low", 64'(bus.s_ready[1]), 64'd0);
        check("bp_m_valid",     64'(bus.m_valid),    64'd1);
        check("bp_m_data_head", 64'(bus.m_data),     64'h12);
        @(negedge clk);
        bus.s_valid[1] = 1'b0;
        bus.m_ready    = 1'b1;
        repeat (40) @(negedge clk);
        check("bp_count", 64'(got.size()), 64'd20);
        for (int k = 0; k < got.size() && k < 20; k++)
            check($sformatf("bp_byte%0d", k), 64'(got[k]), 64'(pat[k % 4]));
        got.delete();
        check("bp_idle", 64'(idle), 64'd1);

        // Reset with 13 bits pending and 5 bytes queued.
        bus.m_ready = 1'b0;
        apply(1, 6'd32, 32'h1122_3344, 1'b0, 1'b0);
        apply(1, 6'd8,  32'h55, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        apply(1, 6'd13, 32'h1ABC, 1'b0, 1'b0);
        check("pre_rst_bit_rest", 64'(bit_rest),    64'd5);
        check("pre_rst_m_valid",  64'(bus.m_valid), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_m_valid",  64'(bus.m_valid), 64'd0);
        check("mid_rst_idle",     64'(idle),        64'd1);
        check("mid_rst_bit_rest", 64'(bit_rest),    64'd0);
        check("mid_rst_err",      64'(err),         64'd0);
        rst = 1'b0;
        bus.m_ready = 1'b1;
        got.delete();
        apply(0, 6'd16, 32'hFFD8, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        check_bytes("post_rst", 2, 48'hFFD8_0000_0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
